// File: rtl/ysyx_22050854_ifu_if.sv
// Instruction-memory read channel (AR/R) between the fetch unit and imem.
interface ysyx_22050854_ifu_if;
    logic        arvalid;
    logic [31:0] araddr;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rready;

    modport master (
        output arvalid,
        output araddr,
        output rready,
        input  arready,
        input  rvalid,
        input  rdata,
        input  rresp
    );

    modport slave (
        input  arvalid,
        input  araddr,
        input  rready,
        output arready,
        output rvalid,
        output rdata,
        output rresp
    );
endinterface

// File: rtl/ysyx_22050854_ifu.sv
// Instruction fetch unit: one outstanding AR/R read at a time, presents the
// fetched word to ID and handles boot, redirect flushes, misalignment and bus errors.
module ysyx_22050854_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       advance,
    input  logic [31:0]                next_pc,
    input  logic                       flush,
    input  logic [31:0]                flush_pc,
    ysyx_22050854_ifu_if.master        imem,
    output logic                       IDreg_valid,
    output logic [31:0]                id_pc,
    output logic [31:0]                id_inst,
    output logic                       id_fault
);

    typedef enum logic [1:0] {StBoot, StAr, StR, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        drop_q, drop_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        pend_v_q, pend_v_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_fault_q, id_fault_d;
    logic        arvalid_q, rready_q, idv_q;
    logic [31:0] araddr_q;

    // Request to start a new fetch at go_pc this cycle.
    logic        go;
    logic [31:0] go_pc;
    logic        bus_err;

    assign bus_err = (imem.rresp != 2'b00);

    // Next-state logic: each state picks a redirect target, then a common
    // tail turns "start fetch" into AR or, if misaligned, a faulting HOLD.
    always_comb begin
        state_d    = state_q;
        req_pc_d   = req_pc_q;
        drop_d     = drop_q;
        pend_pc_d  = pend_pc_q;
        pend_v_d   = pend_v_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_fault_d = id_fault_q;
        go         = 1'b0;
        go_pc      = req_pc_q;

        unique case (state_q)
            StBoot: begin
                go    = 1'b1;
                go_pc = flush ? flush_pc : RESET_PC;
            end
            StAr: begin
                // Address must still be handed over; remember the redirect.
                if (flush) begin
                    drop_d    = 1'b1;
                    pend_pc_d = flush_pc;
                    pend_v_d  = 1'b1;
                end
                if (imem.arready) begin
                    state_d = StR;
                end
            end
            StR: begin
                if (imem.rvalid) begin
                    if (flush) begin
                        go       = 1'b1;
                        go_pc    = flush_pc;
                        drop_d   = 1'b0;
                        pend_v_d = 1'b0;
                    end else if (drop_q) begin
                        drop_d   = 1'b0;
                        go       = 1'b1;
                        go_pc    = pend_v_q ? pend_pc_q : req_pc_q;
                        pend_v_d = 1'b0;
                    end else begin
                        state_d    = StHold;
                        id_pc_d    = req_pc_q;
                        id_inst_d  = bus_err ? NOP_INST : imem.rdata;
                        id_fault_d = bus_err;
                    end
                end else if (flush) begin
                    drop_d    = 1'b1;
                    pend_pc_d = flush_pc;
                    pend_v_d  = 1'b1;
                end
            end
            StHold: begin
                if (flush) begin
                    go    = 1'b1;
                    go_pc = flush_pc;
                end else if (advance) begin
                    go    = 1'b1;
                    go_pc = next_pc;
                end
            end
        endcase

        if (go) begin
            req_pc_d = go_pc;
            if (go_pc[1:0] != 2'b00) begin
                state_d    = StHold;
                id_pc_d    = go_pc;
                id_inst_d  = NOP_INST;
                id_fault_d = 1'b1;
            end else begin
                state_d = StAr;
            end
        end
    end

    // State and registered outputs; outputs are decoded from the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StBoot;
            req_pc_q   <= RESET_PC;
            drop_q     <= 1'b0;
            pend_pc_q  <= 32'h0;
            pend_v_q   <= 1'b0;
            id_pc_q    <= RESET_PC;
            id_inst_q  <= NOP_INST;
            id_fault_q <= 1'b0;
            arvalid_q  <= 1'b0;
            araddr_q   <= RESET_PC;
            rready_q   <= 1'b0;
            idv_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_pc_q   <= req_pc_d;
            drop_q     <= drop_d;
            pend_pc_q  <= pend_pc_d;
            pend_v_q   <= pend_v_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_fault_q <= id_fault_d;
            arvalid_q  <= (state_d == StAr);
            araddr_q   <= req_pc_d;
            rready_q   <= (state_d == StR);
            idv_q      <= (state_d == StHold);
        end
    end

    assign imem.arvalid = arvalid_q;
    assign imem.araddr  = araddr_q;
    assign imem.rready  = rready_q;
    assign IDreg_valid  = idv_q;
    assign id_pc        = id_pc_q;
    assign id_inst      = id_inst_q;
    assign id_fault     = id_fault_q;

endmodule

// File: tb/tb_ysyx_22050854_ifu.sv
// Bench for the fetch unit: a timing-configurable memory responder plus a
// reference model that only tracks "which PC must be presented next".
module tb_ysyx_22050854_ifu;

    localparam logic [31:0] RstPc   = 32'h8000_0000;
    localparam logic [31:0] NopInst = 32'h0000_0013;

    logic        clock;
    logic        reset;
    logic        advance;
    logic [31:0] next_pc;
    logic        flush;
    logic [31:0] flush_pc;
    logic        IDreg_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_fault;

    int tests = 0;
    int fails = 0;

    // Memory responder state
    logic        ar_busy;
    int          ar_wait, r_wait, ar_lat, r_lat;
    logic [31:0] resp_addr;
    logic        rand_lat;

    // Reference model: the PC whose instruction must appear next
    logic [31:0] exp_pc;
    logic        awaiting;

    ysyx_22050854_ifu_if imem ();

    ysyx_22050854_ifu #(
        .RESET_PC (RstPc),
        .NOP_INST (NopInst)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .advance     (advance),
        .next_pc     (next_pc),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .imem        (imem),
        .IDreg_valid (IDreg_valid),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .id_fault    (id_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RstPc) return 32'h0010_0093;
        return {a[13:2], a[31:28], 16'h0093};
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return a[5:2] == 4'hb;
    endfunction

    function automatic logic exp_fault_of(input logic [31:0] a);
        return (a[1:0] != 2'b00) || mem_err(a);
    endfunction

    function automatic logic [31:0] exp_inst_of(input logic [31:0] a);
        return exp_fault_of(a) ? NopInst : mem_word(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic mem_reset();
        ar_busy      = 1'b0;
        ar_wait      = 0;
        r_wait       = 0;
        imem.arready = 1'b0;
        imem.rvalid  = 1'b0;
        imem.rdata   = 32'h0;
        imem.rresp   = 2'b00;
    endtask

    // Drive memory inputs for the coming edge from the current DUT outputs.
    task automatic mem_drive();
        imem.arready = 1'b0;
        imem.rvalid  = 1'b0;
        imem.rdata   = 32'h0;
        imem.rresp   = 2'b00;
        if (ar_busy) begin
            if (r_wait >= r_lat) begin
                imem.rvalid = 1'b1;
                imem.rdata  = mem_word(resp_addr);
                imem.rresp  = mem_err(resp_addr) ? 2'b10 : 2'b00;
            end
            r_wait++;
        end else if (imem.arvalid) begin
            if (ar_wait >= ar_lat) imem.arready = 1'b1;
            ar_wait++;
        end
    endtask

    // Advance one clock; check bus rules and any due presentation.
    task automatic step();
        logic        hs_ar, hs_r, pre_wait;
        logic [31:0] pre_addr;
        hs_ar    = imem.arvalid && imem.arready;
        hs_r     = imem.rvalid && imem.rready;
        pre_wait = imem.arvalid && !imem.arready && reset;
        pre_addr = imem.araddr;
        @(posedge clock);
        #1;
        if (hs_ar) begin
            ar_busy   = 1'b1;
            resp_addr = pre_addr;
            ar_wait   = 0;
            r_wait    = 0;
            if (rand_lat) begin
                ar_lat = $urandom_range(0, 3);
                r_lat  = $urandom_range(0, 3);
            end
        end
        if (hs_r) ar_busy = 1'b0;
        chk("ar_r_exclusive", 32'(imem.arvalid & imem.rready), 32'h0);
        if (pre_wait) begin
            chk("arvalid_held", 32'(imem.arvalid), 32'h1);
            chk("araddr_stable", imem.araddr, pre_addr);
        end
        if (awaiting && IDreg_valid) begin
            chk("id_pc", id_pc, exp_pc);
            chk("id_inst", id_inst, exp_inst_of(exp_pc));
            chk("id_fault", 32'(id_fault), 32'(exp_fault_of(exp_pc)));
            awaiting = 1'b0;
        end
        mem_drive();
    endtask

    task automatic wait_present(input string tag);
        for (int i = 0; i < 60 && awaiting; i++) step();
        chk({tag, "_timeout"}, 32'(awaiting), 32'h0);
    endtask

    task automatic wait_arvalid(input string tag, input logic [31:0] addr);
        for (int i = 0; i < 60 && !imem.arvalid; i++) step();
        chk({tag, "_arvalid"}, 32'(imem.arvalid), 32'h1);
        chk({tag, "_araddr"}, imem.araddr, addr);
    endtask

    task automatic do_adv(input logic [31:0] pc);
        advance = 1'b1;
        next_pc = pc;
        if (IDreg_valid) begin
            exp_pc   = pc;
            awaiting = 1'b1;
        end
        step();
        advance = 1'b0;
    endtask

    task automatic do_flush(input logic [31:0] pc);
        flush    = 1'b1;
        flush_pc = pc;
        exp_pc   = pc;
        awaiting = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_arvalid"}, 32'(imem.arvalid), 32'h0);
        chk({tag, "_araddr"}, imem.araddr, RstPc);
        chk({tag, "_rready"}, 32'(imem.rready), 32'h0);
        chk({tag, "_idv"}, 32'(IDreg_valid), 32'h0);
        chk({tag, "_id_pc"}, id_pc, RstPc);
        chk({tag, "_id_inst"}, id_inst, NopInst);
        chk({tag, "_id_fault"}, 32'(id_fault), 32'h0);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        pc = RstPc + ($urandom_range(0, 63) << 2);
        if ($urandom_range(0, 7) == 0) pc = pc + $urandom_range(1, 3);
        return pc;
    endfunction

    initial begin
        reset    = 1'b1;
        advance  = 1'b0;
        flush    = 1'b0;
        next_pc  = 32'h0;
        flush_pc = 32'h0;
        rand_lat = 1'b0;
        ar_lat   = 0;
        r_lat    = 0;
        resp_addr = 32'h0;
        exp_pc   = RstPc;
        awaiting = 1'b1;
        mem_reset();
        #1 reset = 1'b0;
        #1 chk_reset_vals("por");
        step();
        step();
        chk("por_hold_arvalid", 32'(imem.arvalid), 32'h0);
        reset = 1'b1;

        // Boot with zero-wait memory
        step();
        chk("boot_arvalid", 32'(imem.arvalid), 32'h1);
        chk("boot_araddr", imem.araddr, RstPc);
        step();
        chk("boot_rready", 32'(imem.rready), 32'h1);
        chk("boot_idv_low", 32'(IDreg_valid), 32'h0);
        step();
        chk("boot_idv", 32'(IDreg_valid), 32'h1);
        chk("boot_present_done", 32'(awaiting), 32'h0);

        // Delayed arready: address held, nothing presented
        ar_lat = 3;
        do_adv(32'h8000_0004);
        for (int i = 0; i < 3; i++) begin
            chk("slow_ar_araddr", imem.araddr, 32'h8000_0004);
            chk("slow_ar_idv", 32'(IDreg_valid), 32'h0);
            step();
        end
        wait_present("slow_ar");
        ar_lat = 0;

        // Flush while waiting in R
        r_lat = 3;
        do_adv(32'h8000_0008);
        step();
        chk("flushR_rready", 32'(imem.rready), 32'h1);
        do_flush(32'h8000_0100);
        wait_arvalid("flushR", 32'h8000_0100);
        wait_present("flushR");
        r_lat = 0;

        // Misaligned next_pc
        do_adv(32'h8000_0006);
        chk("misal_arvalid", 32'(imem.arvalid), 32'h0);
        chk("misal_idv", 32'(IDreg_valid), 32'h1);
        chk("misal_presented", 32'(awaiting), 32'h0);

        // Bus error then a clean fetch
        do_adv(32'h8000_002c);
        wait_present("buserr");
        do_adv(32'h8000_0030);
        wait_present("after_err");

        // Flush and advance together in HOLD
        advance  = 1'b1;
        next_pc  = 32'h8000_0008;
        flush    = 1'b1;
        flush_pc = 32'h8000_0200;
        exp_pc   = 32'h8000_0200;
        awaiting = 1'b1;
        step();
        advance = 1'b0;
        flush   = 1'b0;
        chk("flush_adv_araddr", imem.araddr, 32'h8000_0200);
        wait_present("flush_adv");

        // Advance ignored outside HOLD
        r_lat = 2;
        do_adv(32'h8000_0010);
        advance = 1'b1;
        next_pc = 32'h8000_0044;
        step();
        advance = 1'b0;
        chk("reset_mid_rready", 32'(imem.rready), 32'h1);

        // Asynchronous reset in R
        reset = 1'b0;
        #1;
        chk_reset_vals("rst_in_r");
        mem_reset();
        exp_pc   = RstPc;
        awaiting = 1'b1;
        step();
        chk("rst_hold_arvalid", 32'(imem.arvalid), 32'h0);
        reset = 1'b1;
        r_lat = 0;
        wait_present("reboot");

        // Randomized traffic
        rand_lat = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic do_f, do_a;
            do_f = ($urandom_range(0, 9) == 0);
            do_a = ($urandom_range(0, 2) == 0);
            flush    = do_f;
            flush_pc = rand_pc();
            advance  = do_a;
            next_pc  = rand_pc();
            if (do_f) begin
                exp_pc   = flush_pc;
                awaiting = 1'b1;
            end else if (do_a && IDreg_valid) begin
                exp_pc   = next_pc;
                awaiting = 1'b1;
            end
            step();
            flush   = 1'b0;
            advance = 1'b0;
        end
        wait_present("random_tail");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
